// File: rtl/bcd_convert_seq_if.sv
// Request/result bundle for bcd_convert_seq; bcd_ovf is present only when BCD_SAT_EN is defined.
interface bcd_convert_seq_if #(
  parameter int unsigned DATA_W  = 20,
  parameter int unsigned DIG_NUM = 6
);
  logic [DATA_W-1:0]    data_in;
  logic                 data_valid;
  logic                 busy;
  logic [4*DIG_NUM-1:0] bcd_out;
  logic                 bcd_valid;
`ifdef BCD_SAT_EN
  logic                 bcd_ovf;

  modport master (output data_in, data_valid, input busy, bcd_out, bcd_valid, bcd_ovf);
  modport slave  (input data_in, data_valid, output busy, bcd_out, bcd_valid, bcd_ovf);
`else
  modport master (output data_in, data_valid, input busy, bcd_out, bcd_valid);
  modport slave  (input data_in, data_valid, output busy, bcd_out, bcd_valid);
`endif
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock.
// Optional saturation on overflow is enabled by defining BCD_SAT_EN.
module bcd_convert_seq #(
  parameter int unsigned DATA_W  = 20,
  parameter int unsigned DIG_NUM = 6
) (
  input logic               sys_clk,
  input logic               sys_rst,
  bcd_convert_seq_if.slave  bus
);

  localparam int unsigned NIB   = DIG_NUM + 1;
  localparam int unsigned BCD_W = 4 * NIB;
  localparam int unsigned OUT_W = 4 * DIG_NUM;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  bin_sr, bin_nxt;
  logic [BCD_W-1:0]   bcd_sr, bcd_nxt, adj;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OUT_W-1:0]   out_q, out_nxt;
  logic               valid_q, valid_nxt;
  logic               busy_q, busy_nxt;
  logic               ovf_q, ovf_nxt;
  logic [BCD_W+DATA_W-1:0] shifted;

  // Register stage: FSM state, shift datapath and all outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bin_sr  <= bin_nxt;
      bcd_sr  <= bcd_nxt;
      cnt     <= cnt_nxt;
      out_q   <= out_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_sr;
    bcd_nxt   = bcd_sr;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    valid_nxt = 1'b0;
    ovf_nxt   = ovf_q;
    adj       = bcd_sr;

    // Add-3 on every nibble >= 5 before the shift keeps each digit within 0..9
    for (int unsigned i = 0; i < NIB; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_sr} << 1;

    case (state)
      IDLE: begin
        if (bus.data_valid) begin
          bin_nxt   = bus.data_in;
          bcd_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_nxt, bin_nxt} = shifted;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          valid_nxt = 1'b1;
          state_nxt = DONE;
`ifdef BCD_SAT_EN
          if (shifted[BCD_W+DATA_W-1 -: 4] != 4'd0) begin
            out_nxt = {DIG_NUM{4'h9}};
            ovf_nxt = 1'b1;
          end else begin
            out_nxt = shifted[DATA_W +: OUT_W];
            ovf_nxt = 1'b0;
          end
`else
          out_nxt = shifted[DATA_W +: OUT_W];
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.bcd_out   = out_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy      = busy_q;
`ifdef BCD_SAT_EN
  assign bus.bcd_ovf   = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq against a decimal-arithmetic reference model.
module tb_bcd_convert_seq;

  localparam int unsigned DATA_W  = 20;
  localparam int unsigned DIG_NUM = 6;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   tests = 0;
  int   fails = 0;

  bcd_convert_seq_if #(.DATA_W(DATA_W), .DIG_NUM(DIG_NUM)) bus ();

  bcd_convert_seq #(.DATA_W(DATA_W), .DIG_NUM(DIG_NUM)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference: decimal digits by repeated division, saturating or wrapping at 10^DIG_NUM
  function automatic logic [31:0] ref_bcd(input int unsigned v, output logic ovf);
    int unsigned t;
    logic [31:0] r;
    r   = '0;
    ovf = 1'b0;
`ifdef BCD_SAT_EN
    if (v > 999999) begin
      ovf = 1'b1;
      return 32'h00999999;
    end
`endif
    t = v % 1000000;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until bcd_valid is seen; -1 if the budget runs out
  task automatic wait_valid(input int max, output int k);
    k = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (bus.bcd_valid) begin
        k = i;
        break;
      end
    end
  endtask

  // One request from a negedge; checks busy, latency, result, strobe width
  task automatic convert(input string tag, input int unsigned v);
    int k;
    logic [31:0] exp;
    logic eovf;
    exp = ref_bcd(v, eovf);
    bus.data_in    = DATA_W'(v);
    bus.data_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.data_valid = 1'b0;
    bus.data_in    = DATA_W'($urandom);
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    wait_valid(40, k);
    check({tag, " latency"}, 32'(k), 32'd20);
    check({tag, " bcd_out"}, 32'(bus.bcd_out), exp);
`ifdef BCD_SAT_EN
    check({tag, " bcd_ovf"}, 32'(bus.bcd_ovf), 32'(eovf));
`endif
    @(posedge sys_clk);
    @(negedge sys_clk);
    check({tag, " strobe_clear"}, 32'(bus.bcd_valid), 32'd0);
    check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int k;
    int pulses;
    logic [31:0] first_out;
    logic eovf;

    sys_rst        = 1'b1;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst bcd_out", 32'(bus.bcd_out), 32'd0);
    check("rst bcd_valid", 32'(bus.bcd_valid), 32'd0);
`ifdef BCD_SAT_EN
    check("rst bcd_ovf", 32'(bus.bcd_ovf), 32'd0);
`endif
    sys_rst = 1'b0;
    @(negedge sys_clk);

    convert("v123456", 123456);
    convert("v0", 0);
    convert("v999999", 999999);
    convert("v1048575", 1048575);
    convert("v1000000", 1000000);
    for (int i = 0; i < 8; i++) convert("rand", $urandom_range(0, 1048575));

    // Second request arriving during SHIFT is dropped
    bus.data_in    = DATA_W'(111111);
    bus.data_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.data_valid = 1'b0;
    pulses    = 0;
    first_out = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      bus.data_valid = (i == 4);
      bus.data_in    = (i == 4) ? DATA_W'(222222) : DATA_W'($urandom);
      if (i == 5) check("drop busy_mid", 32'(bus.busy), 32'd1);
      if (i == 20) check("drop busy_done", 32'(bus.busy), 32'd1);
      if (i == 21) check("drop busy_end", 32'(bus.busy), 32'd0);
      if (bus.bcd_valid) begin
        if (pulses == 0) begin
          first_out = 32'(bus.bcd_out);
          check("drop latency", 32'(i), 32'd20);
        end
        pulses++;
      end
    end
    bus.data_valid = 1'b0;
    check("drop result", first_out, 32'h00111111);
    check("drop pulses", 32'(pulses), 32'd1);

    // Continuous requests: one result every DATA_W+2 clocks
    bus.data_in    = DATA_W'(42);
    bus.data_valid = 1'b1;
    wait_valid(40, k);
    check("cont first", 32'(k), 32'd21);
    check("cont out1", 32'(bus.bcd_out), ref_bcd(42, eovf));
    wait_valid(40, k);
    check("cont period", 32'(k), 32'd22);
    check("cont out2", 32'(bus.bcd_out), 32'h00000042);
    bus.data_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("cont idle", 32'(bus.busy), 32'd0);

    // Reset during SHIFT discards the conversion and clears the held result
    bus.data_in    = DATA_W'(777777);
    bus.data_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.data_valid = 1'b0;
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    check("prerst hold", 32'(bus.bcd_out), 32'h00000042);
    sys_rst = 1'b1;
    #1;
    check("midrst bcd_out", 32'(bus.bcd_out), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (bus.bcd_valid) pulses++;
    end
    check("postrst no_valid", 32'(pulses), 32'd0);
    convert("postrst", $urandom_range(0, 999999));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
